// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI serial receive path.
// Holds the baud-rate constants and the receiver state encoding.
package midi_pkg;

   localparam int unsigned MIDI_BAUD = 31250;
   localparam int unsigned SYS_CLK_HZ = 12_000_000;
   localparam int unsigned MIDI_CLKS_PER_BIT = SYS_CLK_HZ / MIDI_BAUD;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } rx_state_e;

endpackage

// File: rtl/midi_bit_timer.sv
// Down-counting bit timer: loaded with a half- or full-bit interval, ticks when it hits zero.
// It holds at zero until reloaded, so each sample point restarts the interval.
module midi_bit_timer
   import midi_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic half,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   // Terminal value is zero, so load one less than the wanted interval.
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= half ? HALF_LOAD : FULL_LOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/midi_uart_rx.sv
// 8N1 MIDI receiver with a one-entry holding register, overrun flag and framing-error pulse.
// Returns to idle mid stop bit so back-to-back frames resynchronise on each start edge.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       ack,
   output logic [7:0] data,
   output logic       valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("CLKS_PER_BIT must be at least 4");
   end

   rx_state_e  state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       tick;
   logic       load;
   logic       half;
   logic       deliver;

   midi_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk (clk),
      .rst (rst),
      .load(load),
      .half(half),
      .tick(tick)
   );

   always_comb begin
      load = 1'b0;
      half = 1'b0;
      case (state)
         StIdle: begin
            load = ~rx;
            half = 1'b1;
         end
         StStart: load = tick & ~rx;
         StData:  load = tick;
         default: ;
      endcase
   end

   assign deliver = (state == StStop) && tick && rx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         bit_cnt   <= '0;
         shift     <= '0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            StIdle: begin
               if (!rx) begin
                  state   <= StStart;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            StStart: begin
               if (tick) begin
                  if (rx) begin
                     state <= StIdle;
                     busy  <= 1'b0;
                  end else begin
                     state <= StData;
                  end
               end
            end
            StData: begin
               if (tick) begin
                  shift   <= {rx, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= StStop;
                  end
               end
            end
            StStop: begin
               if (tick) begin
                  if (rx) begin
                     state <= StIdle;
                     busy  <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= StBreak;
                  end
               end
            end
            StBreak: begin
               if (rx) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // An ack in the delivery cycle frees the slot for the new byte; overrun is left alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         data    <= 8'h00;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else if (deliver) begin
         if (!valid || ack) begin
            data  <= shift;
            valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (valid && ack) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at 8 clocks per bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_midi_uart_rx;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       ack;
   logic [7:0] data;
   logic       valid;
   logic       overrun;
   logic       frame_err;
   logic       busy;

   int n_pass = 0;
   int n_fail = 0;

   midi_uart_rx #(
      .CLKS_PER_BIT(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .ack      (ack),
      .data     (data),
      .valid    (valid),
      .overrun  (overrun),
      .frame_err(frame_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   // Start bit plus eight data bits (72 cycles); leaves rx high for the stop bit.
   task automatic send_head(input logic [7:0] d);
      drive_bit(1'b0, 8);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 8);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_head(d);
      drive_bit(1'b1, 8);
   endtask

   initial begin
      int fe_pulses;
      int valid_seen;

      rst = 1'b1;
      rx  = 1'b1;
      ack = 1'b0;
      repeat (3) @(negedge clk);
      check("reset data", data, 8'h00);
      check("reset valid", valid, 0);
      check("reset overrun", overrun, 0);
      check("reset frame_err", frame_err, 0);
      check("reset busy", busy, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte: valid appears exactly on T+77.
      send_head(8'h90);
      repeat (4) @(negedge clk);
      check("t1 valid before T+77", valid, 0);
      check("t1 busy before stop", busy, 1);
      @(negedge clk);
      check("t1 valid at T+77", valid, 1);
      check("t1 data", data, 8'h90);
      check("t1 busy after stop", busy, 0);
      check("t1 frame_err", frame_err, 0);
      repeat (3) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("t1 ack clears valid", valid, 0);
      repeat (10) @(negedge clk);

      // Three-cycle glitch is rejected at the start-bit sample.
      drive_bit(1'b0, 3);
      check("t2 busy during glitch", busy, 1);
      drive_bit(1'b1, 2);
      check("t2 busy by T+5", busy, 0);
      check("t2 valid", valid, 0);
      check("t2 frame_err", frame_err, 0);
      repeat (10) @(negedge clk);

      // Stop bit held low for 20 cycles: one frame_err pulse, no byte.
      send_head(8'h3C);
      rx = 1'b0;
      fe_pulses  = 0;
      valid_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (frame_err) fe_pulses++;
         if (valid) valid_seen++;
      end
      check("t3 frame_err pulses", 8'(fe_pulses), 8'd1);
      check("t3 valid cycles", 8'(valid_seen), 8'd0);
      check("t3 busy in break", busy, 1);
      drive_bit(1'b1, 1);
      check("t3 busy after break", busy, 0);
      check("t3 valid after break", valid, 0);
      repeat (10) @(negedge clk);

      // Back-to-back bytes with no ack: second and third are lost.
      send_frame(8'h90);
      check("t4 first valid", valid, 1);
      check("t4 overrun after first", overrun, 0);
      send_frame(8'h40);
      check("t4 overrun after second", overrun, 1);
      check("t4 data keeps first", data, 8'h90);
      send_frame(8'h7F);
      check("t4 overrun sticky", overrun, 1);
      check("t4 data still first", data, 8'h90);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("t4 ack clears valid", valid, 0);
      check("t4 ack clears overrun", overrun, 0);
      repeat (10) @(negedge clk);

      // Ack coincident with delivery of the second byte.
      send_frame(8'h90);
      send_head(8'h40);
      repeat (4) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("t5 data second", data, 8'h40);
      check("t5 valid", valid, 1);
      check("t5 overrun", overrun, 0);
      repeat (3) @(negedge clk);

      // Reset in the middle of bit 4, then a clean 8'hF8.
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
      drive_bit(1'b0, 4);
      check("t6 busy mid-frame", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("t6 reset data", data, 8'h00);
      check("t6 reset valid", valid, 0);
      check("t6 reset overrun", overrun, 0);
      check("t6 reset frame_err", frame_err, 0);
      check("t6 reset busy", busy, 0);
      rst = 1'b0;
      drive_bit(1'b1, 20);
      send_frame(8'hF8);
      check("t6 fresh valid", valid, 1);
      check("t6 fresh data", data, 8'hF8);
      check("t6 fresh overrun", overrun, 0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial receiver for 31.25 kbaud MIDI: the receive-side counterpart of the `uart_tx` output path. It takes one synchronizer output (`midi_sync[n]`) and recovers 8N1 frames, LSB first. Each received byte goes into a one-entry holding register with a valid/ack handshake. One instance is placed per MIDI input, feeding the router's merge/SPI readback logic.

## Interface
- `CLKS_PER_BIT`, default 384 (12 MHz / 31 250). Must be ≥ 4. Clock cycles per bit.
- `clk`  input  1  System clock. Single clock domain.
- `rst`  input  1  Synchronous, active-high reset.
- `rx`  input  1  Serial line, already synchronized to `clk`. Idle high.
- `ack`  input  1  Consumer read strobe. Ignored when `valid`=0.
- `data`  output  8  Received byte. Stable while `valid`=1.
- `valid`  output  1  Holding register full.
- `overrun`  output  1  Sticky flag: a byte was lost because the holding register was full.
- `frame_err`  output  1  One-cycle pulse: stop bit was sampled low.
- `busy`  output  1  High in every state except IDLE.

## Operation
- States:
  - **IDLE**: wait for `rx`=0, then go to START and clear the bit counter.
  - **START**: wait `CLKS_PER_BIT/2` cycles (floor), then sample `rx`.
    - If `rx`=1, treat it as a glitch and return to IDLE. No flags are raised.
    - If `rx`=0, go to DATA.
  - **DATA**: sample `rx` every `CLKS_PER_BIT` cycles and shift it in LSB first. After the 8th sample, go to STOP.
  - **STOP**: wait `CLKS_PER_BIT` cycles, then sample `rx`.
    - If `rx`=1, deliver the byte and go to IDLE.
    - If `rx`=0, pulse `frame_err`, discard the byte, and go to BREAK.
  - **BREAK**: wait for `rx`=1, then go to IDLE. Line breaks and held-low lines never generate bytes.
- The receiver returns to IDLE at the middle of the stop bit. This allows resynchronization on back-to-back frames.
- Delivery when `valid`=0: load `data` and set `valid`=1.
- Delivery when `valid`=1 and `ack`=0: drop the new byte and set `overrun`=1. `data` keeps the old byte.
- Delivery when `valid`=1 and `ack`=1 in the same cycle: load the new byte. `valid` stays 1 and `overrun` is unchanged.
- `ack` with `valid`=1 and no delivery: `valid`→0 on the next edge. `overrun` also clears on that same `ack`.
- Bit-timer counter width: `$clog2(CLKS_PER_BIT)`. It reloads on every sample; there is no free-running wrap.
- Reset is synchronous and active-high and overrides everything, including mid-frame. After reset:
  - state = IDLE, counters = 0, shift register = 0;
  - `data`=8'h00, `valid`=0, `overrun`=0, `frame_err`=0, `busy`=0.
  - A frame in progress is abandoned. If `rx` is still low after reset, the receiver resynchronizes on that low as a start bit; the corrupted frame is then rejected by the stop-bit check.

## Timing
- Let T be the cycle in which IDLE first sees `rx`=0.
- Start-bit sample: T + `CLKS_PER_BIT/2`.
- Data bit i (i = 0..7) sample: T + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
- Stop-bit sample: T + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- `valid` or `frame_err` is registered and becomes visible on the cycle after the stop sample.
- `busy` rises on T+1. It falls the cycle after the stop sample, or on the cycle after `rx` goes high in BREAK.
- `ack` is sampled every cycle. Maximum throughput is one byte per 10 bit times; no bubble is required.

## Structure
- Shared package `midi_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - `MIDI_BAUD` = 31250;
  - a helper constant for `CLKS_PER_BIT`, derived from the clock frequency.
- One natural sub-module: `midi_bit_timer`.
  - Inputs: load.
  - Outputs: `tick` when the count reaches the terminal value.
  - Loaded with half- or full-bit values by the FSM.
- Holding register and flags stay in the top-level block.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
- Byte 8'h90 sent as 8N1 → `data`=8'h90 and `valid`=1 exactly 77 cycles after the start edge (T+4+72+1). `ack` then clears `valid`.
- Low pulse of 3 cycles on idle line → no `valid`, no `frame_err`, `busy` back to 0 by T+5.
- Frame 8'h3C with stop bit forced low for 20 cycles → `frame_err` pulses once, `valid` stays 0, no new byte until `rx` returns high.
- Bytes 8'h90, 8'h40, 8'h7F sent back-to-back with no `ack` → `data`=8'h90, `overrun`=1 after the second byte, and it stays 1. `ack` clears both `valid` and `overrun`.
- `ack` asserted in the delivery cycle of the second byte → `data`=8'h40, `valid`=1, `overrun`=0.
- `rst` asserted mid-frame (bit 4) → all outputs at reset values next cycle. A fresh 8'hF8 frame afterwards is received correctly.
